// File: rtl/qed_check_pkg.sv
// Shared types, mode encodings and derived-size helpers for the QED consistency checker.
package qed_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Trigger mode encodings
  localparam int unsigned MODE_CHECK_ONLY = 0;
  localparam int unsigned MODE_ENTRY      = 1;

  // Number of scan beats for a given pair count, zero-skip and lane count
  function automatic int unsigned calc_nbeats(input int unsigned po, input int unsigned sz,
                                              input int unsigned lanes);
    return (po - sz + lanes - 1) / lanes;
  endfunction

  // Width of an original-register index (at least one bit)
  function automatic int unsigned calc_idx_w(input int unsigned po);
    return (po > 1) ? $clog2(po) : 1;
  endfunction

  // Width of the scan pointer; must hold idx + LANES without wrapping
  function automatic int unsigned calc_scan_w(input int unsigned po, input int unsigned lanes);
    return $clog2(po + lanes + 1);
  endfunction

  // Values for the default configuration
  localparam int unsigned NBEATS = calc_nbeats(16, 1, 4);
  localparam int unsigned IDX_W  = calc_idx_w(16);

endpackage

// File: rtl/qed_consistency_checker_if.sv
// Monitor-side bus: register file and trigger inputs, status and counter outputs.
interface qed_consistency_checker_if
  import qed_check_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned PAIR_OFFSET = NREGS / 2,
  parameter int unsigned CNT_W       = 16
) ();

  localparam int unsigned EIDX_W = calc_idx_w(PAIR_OFFSET);

  logic [NREGS*XLEN-1:0] regs_flat;
  logic                  commit;
  logic                  commit_pulse;
  logic                  check_valid;
  logic                  clear_err;

  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  err_sticky;
  logic [EIDX_W-1:0]     err_idx;
  logic [XLEN-1:0]       err_orig;
  logic [XLEN-1:0]       err_dup;
  logic                  zero_err;
  logic [CNT_W-1:0]      check_cnt;
  logic [CNT_W-1:0]      overrun_cnt;

  modport master (
    output regs_flat, commit, commit_pulse, check_valid, clear_err,
    input  busy, done, pass, err_sticky, err_idx, err_orig, err_dup,
           zero_err, check_cnt, overrun_cnt
  );

  modport slave (
    input  regs_flat, commit, commit_pulse, check_valid, clear_err,
    output busy, done, pass, err_sticky, err_idx, err_orig, err_dup,
           zero_err, check_cnt, overrun_cnt
  );

endinterface

// File: rtl/qed_pair_compare.sv
// LANES-wide original/duplicate comparator with lowest-index priority select.
module qed_pair_compare
  import qed_check_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned PAIR_OFFSET = NREGS / 2,
  parameter int unsigned LANES       = 4
) (
  input  logic [calc_scan_w(PAIR_OFFSET, LANES)-1:0] base,
  input  logic [NREGS*XLEN-1:0]                      snap,
  output logic                                       any_mismatch_c,
  output logic [calc_idx_w(PAIR_OFFSET)-1:0]         mm_idx_c,
  output logic [XLEN-1:0]                            mm_orig_c,
  output logic [XLEN-1:0]                            mm_dup_c
);

  localparam int unsigned SCAN_W = calc_scan_w(PAIR_OFFSET, LANES);
  localparam int unsigned EIDX_W = calc_idx_w(PAIR_OFFSET);
  localparam int unsigned RI_W   = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0]   regs      [NREGS];
  logic [SCAN_W-1:0] lane_j    [LANES];
  logic [XLEN-1:0]   lane_orig [LANES];
  logic [XLEN-1:0]   lane_dup  [LANES];
  logic              lane_hit  [LANES];

  // Unpack the snapshot into addressable registers
  for (genvar k = 0; k < NREGS; k++) begin : g_reg
    assign regs[k] = snap[k*XLEN +: XLEN];
  end

  // Per-lane pair fetch; lanes past the last original are masked off
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic              lane_ok;
    logic [SCAN_W-1:0] jc;
    assign lane_j[l]    = base + SCAN_W'(l);
    assign lane_ok      = (lane_j[l] < SCAN_W'(PAIR_OFFSET));
    assign jc           = lane_ok ? lane_j[l] : '0;
    assign lane_orig[l] = regs[RI_W'(jc)];
    assign lane_dup[l]  = regs[RI_W'(jc) + RI_W'(PAIR_OFFSET)];
    assign lane_hit[l]  = lane_ok && (lane_orig[l] != lane_dup[l]);
  end

  // Priority encoder: highest lane first so the lowest failing index wins
  always_comb begin
    any_mismatch_c = 1'b0;
    mm_idx_c       = '0;
    mm_orig_c      = '0;
    mm_dup_c       = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        any_mismatch_c = 1'b1;
        mm_idx_c       = EIDX_W'(lane_j[l]);
        mm_orig_c      = lane_orig[l];
        mm_dup_c       = lane_dup[l];
      end
    end
  end

endmodule

// File: rtl/qed_consistency_checker.sv
// Snapshot-and-scan QED consistency checker: FSM, snapshot, counters and sticky flags.
module qed_consistency_checker
  import qed_check_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREGS       = 32,
  parameter int unsigned PAIR_OFFSET = NREGS / 2,
  parameter int unsigned LANES       = 4,
  parameter int unsigned SKIP_ZERO   = 1,
  parameter int unsigned MODE        = 0,
  parameter int unsigned CNT_W       = 16
) (
  input logic                      clk,
  input logic                      rst,
  qed_consistency_checker_if.slave bus
);

  localparam int unsigned SCAN_W = calc_scan_w(PAIR_OFFSET, LANES);
  localparam int unsigned EIDX_W = calc_idx_w(PAIR_OFFSET);
  localparam logic [SCAN_W-1:0] START_IDX = SCAN_W'((SKIP_ZERO != 0) ? 1 : 0);

  state_e                state;
  logic [NREGS*XLEN-1:0] snap;
  logic [SCAN_W-1:0]     idx;
  logic [EIDX_W-1:0]     fail_idx;
  logic [XLEN-1:0]       fail_orig;
  logic [XLEN-1:0]       fail_dup;

  logic                  trig_c;
  logic                  zero_hit_c;
  logic                  last_beat_c;
  logic                  any_mismatch_c;
  logic [EIDX_W-1:0]     mm_idx_c;
  logic [XLEN-1:0]       mm_orig_c;
  logic [XLEN-1:0]       mm_dup_c;

  // Trigger, zero-register probe on live values (equal to the snapshot taken this cycle), last-beat test
  assign trig_c      = (bus.check_valid && bus.commit) ||
                       ((MODE == MODE_ENTRY) && bus.commit_pulse);
  assign zero_hit_c  = (SKIP_ZERO != 0) &&
                       ((bus.regs_flat[XLEN-1:0] != '0) ||
                        (bus.regs_flat[PAIR_OFFSET*XLEN +: XLEN] != '0));
  assign last_beat_c = (idx + SCAN_W'(LANES)) >= SCAN_W'(PAIR_OFFSET);

  qed_pair_compare #(
    .XLEN        (XLEN),
    .NREGS       (NREGS),
    .PAIR_OFFSET (PAIR_OFFSET),
    .LANES       (LANES)
  ) u_cmp (
    .base           (idx),
    .snap           (snap),
    .any_mismatch_c (any_mismatch_c),
    .mm_idx_c       (mm_idx_c),
    .mm_orig_c      (mm_orig_c),
    .mm_dup_c       (mm_dup_c)
  );

  // Scan FSM with registered status; a failing REPORT overrides a coincident clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      snap            <= '0;
      idx             <= '0;
      fail_idx        <= '0;
      fail_orig       <= '0;
      fail_dup        <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b1;
      bus.err_sticky  <= 1'b0;
      bus.err_idx     <= '0;
      bus.err_orig    <= '0;
      bus.err_dup     <= '0;
      bus.zero_err    <= 1'b0;
      bus.check_cnt   <= '0;
      bus.overrun_cnt <= '0;
    end else begin
      bus.done <= 1'b0;

      if (bus.clear_err) begin
        bus.err_sticky <= 1'b0;
        bus.zero_err   <= 1'b0;
        bus.err_idx    <= '0;
        bus.err_orig   <= '0;
        bus.err_dup    <= '0;
      end

      if (trig_c && (state != IDLE) && (bus.overrun_cnt != '1)) begin
        bus.overrun_cnt <= bus.overrun_cnt + CNT_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (trig_c) begin
            snap     <= bus.regs_flat;
            idx      <= START_IDX;
            bus.busy <= 1'b1;
            state    <= SCAN;
            if (zero_hit_c) bus.zero_err <= 1'b1;
          end
        end
        SCAN: begin
          if (any_mismatch_c) begin
            fail_idx  <= mm_idx_c;
            fail_orig <= mm_orig_c;
            fail_dup  <= mm_dup_c;
            bus.pass  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= REPORT;
          end else if (last_beat_c) begin
            bus.pass <= 1'b1;
            bus.done <= 1'b1;
            state    <= REPORT;
          end else begin
            idx <= idx + SCAN_W'(LANES);
          end
        end
        REPORT: begin
          if (bus.check_cnt != '1) bus.check_cnt <= bus.check_cnt + CNT_W'(1);
          if (!bus.pass) begin
            bus.err_sticky <= 1'b1;
            if (!bus.err_sticky || bus.clear_err) begin
              bus.err_idx  <= fail_idx;
              bus.err_orig <= fail_orig;
              bus.err_dup  <= fail_dup;
            end
          end
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
